// File: rtl/fib_pkg.sv
// Shared types and helpers for the FIB hash memory sequencer.
package fib_pkg;

    localparam int IDX_W   = 10;
    localparam int MAX_LEN = 8;
    localparam int PFX_W   = 64;
    localparam int ENTRY_W = 65;
    localparam int ADDR_W  = 13;

    typedef struct packed {
        logic             valid;
        logic [PFX_W-1:0] prefix;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_CMP,
        ST_WR
    } state_t;

    // Keep the leading len bytes of an MSB-aligned name, zero the rest.
    function automatic logic [PFX_W-1:0] mask_prefix(input logic [PFX_W-1:0] prefix,
                                                      input logic [4:0]       len);
        logic [PFX_W-1:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (5'(b) < len) begin
                m[63-8*b -: 8] = prefix[63-8*b -: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fib_hash.sv
// Combinational XOR fold of a 64-bit key into an IDX_W-bit bucket index, LSB chunk first.
module fib_hash #(
    parameter int IDX_W = 10
) (
    input  logic [63:0]      key,
    output logic [IDX_W-1:0] idx
);

    // Bit i lands on position i mod IDX_W; the short top chunk is implicitly zero-padded.
    always_comb begin
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            idx[i % IDX_W] = idx[i % IDX_W] ^ key[i];
        end
    end

endmodule

// File: rtl/fib_access_arbiter.sv
// Round-robin lookup/insert arbiter sequencing the single-ported FIB memory (hash, read, compare, write).
// Lookups respond 2n+1 cycles after accept (n probes), inserts after 4, illegal lengths after 1; ready only in IDLE.
module fib_access_arbiter #(
    parameter int IDX_W   = 10,
    parameter int MAX_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lk_valid,
    output logic                          lk_ready,
    input  logic [63:0]                   lk_prefix,
    input  logic [4:0]                    lk_len,
    output logic                          lk_resp_valid,
    output logic                          lk_resp_hit,
    output logic [4:0]                    lk_resp_len,
    output logic                          lk_resp_err,
    input  logic                          ins_valid,
    output logic                          ins_ready,
    input  logic [63:0]                   ins_prefix,
    input  logic [4:0]                    ins_len,
    output logic                          ins_resp_valid,
    output logic                          ins_resp_coll,
    output logic                          ins_resp_err,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    output logic [IDX_W+2:0]              mem_addr,
    output logic [fib_pkg::ENTRY_W-1:0]   mem_wdata,
    input  logic [fib_pkg::ENTRY_W-1:0]   mem_rdata
);
    import fib_pkg::*;

    state_t           state_q, state_d;
    logic             is_ins_q, is_ins_d;
    logic             last_ins_q, last_ins_d;
    logic [63:0]      prefix_q, prefix_d;
    logic [4:0]       len_q, len_d;
    logic             coll_q, coll_d;
    logic             mem_rd_en_q, mem_rd_en_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [IDX_W+2:0] mem_addr_q, mem_addr_d;
    entry_t           mem_wdata_q, mem_wdata_d;
    logic             lk_resp_valid_q, lk_resp_valid_d;
    logic             lk_resp_hit_q, lk_resp_hit_d;
    logic [4:0]       lk_resp_len_q, lk_resp_len_d;
    logic             lk_resp_err_q, lk_resp_err_d;
    logic             ins_resp_valid_q, ins_resp_valid_d;
    logic             ins_resp_coll_q, ins_resp_coll_d;
    logic             ins_resp_err_q, ins_resp_err_d;

    logic             in_idle, grant_lk, grant_ins, acc_illegal, rd_match;
    logic [63:0]      acc_prefix, hash_prefix, hash_key, probe_key;
    logic [4:0]       acc_len, hash_len;
    logic [2:0]       probe_bank;
    logic [IDX_W-1:0] hash_idx;
    entry_t           rd_entry;

    // Ties go to whichever side was not granted last; rst masks both readies.
    assign in_idle   = (state_q == ST_IDLE) && !rst;
    assign grant_lk  = in_idle && lk_valid && (!ins_valid || last_ins_q);
    assign grant_ins = in_idle && ins_valid && !grant_lk;
    assign lk_ready  = grant_lk;
    assign ins_ready = grant_ins;

    assign acc_prefix  = grant_lk ? lk_prefix : ins_prefix;
    assign acc_len     = grant_lk ? lk_len : ins_len;
    assign acc_illegal = (acc_len == 5'd0) || (int'(acc_len) > MAX_LEN);

    // The single hash serves both the first probe (from the request) and each shorter retry.
    assign hash_prefix = (state_q == ST_CMP) ? prefix_q : acc_prefix;
    assign hash_len    = (state_q == ST_CMP) ? len_q - 5'd1 : acc_len;
    assign probe_bank  = 3'(hash_len - 5'd1);
    assign hash_key    = mask_prefix(hash_prefix, hash_len);
    assign probe_key   = mask_prefix(prefix_q, len_q);
    assign rd_entry    = mem_rdata;
    assign rd_match    = rd_entry.valid && (rd_entry.prefix == probe_key);

    fib_hash #(.IDX_W(IDX_W)) u_hash (
        .key (hash_key),
        .idx (hash_idx)
    );

    always_comb begin
        state_d          = state_q;
        is_ins_d         = is_ins_q;
        last_ins_d       = last_ins_q;
        prefix_d         = prefix_q;
        len_d            = len_q;
        coll_d           = coll_q;
        mem_rd_en_d      = 1'b0;
        mem_wr_en_d      = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        lk_resp_valid_d  = 1'b0;
        lk_resp_hit_d    = lk_resp_hit_q;
        lk_resp_len_d    = lk_resp_len_q;
        lk_resp_err_d    = lk_resp_err_q;
        ins_resp_valid_d = 1'b0;
        ins_resp_coll_d  = ins_resp_coll_q;
        ins_resp_err_d   = ins_resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_lk || grant_ins) begin
                    last_ins_d = grant_ins;
                    is_ins_d   = grant_ins;
                    prefix_d   = acc_prefix;
                    len_d      = acc_len;
                    if (acc_illegal) begin
                        if (grant_ins) begin
                            ins_resp_valid_d = 1'b1;
                            ins_resp_coll_d  = 1'b0;
                            ins_resp_err_d   = 1'b1;
                        end else begin
                            lk_resp_valid_d = 1'b1;
                            lk_resp_hit_d   = 1'b0;
                            lk_resp_len_d   = 5'd0;
                            lk_resp_err_d   = 1'b1;
                        end
                    end else begin
                        state_d     = ST_RD;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {probe_bank, hash_idx};
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (is_ins_q) begin
                    // Collision is held until WR so the response fields change only with the strobe.
                    coll_d      = rd_entry.valid && !rd_match;
                    mem_wr_en_d = 1'b1;
                    mem_wdata_d = '{valid: 1'b1, prefix: probe_key};
                    state_d     = ST_WR;
                end else if (rd_match) begin
                    lk_resp_valid_d = 1'b1;
                    lk_resp_hit_d   = 1'b1;
                    lk_resp_len_d   = len_q;
                    lk_resp_err_d   = 1'b0;
                    state_d         = ST_IDLE;
                end else if (len_q > 5'd1) begin
                    len_d       = len_q - 5'd1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {probe_bank, hash_idx};
                    state_d     = ST_RD;
                end else begin
                    lk_resp_valid_d = 1'b1;
                    lk_resp_hit_d   = 1'b0;
                    lk_resp_len_d   = 5'd0;
                    lk_resp_err_d   = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            ST_WR: begin
                ins_resp_valid_d = 1'b1;
                ins_resp_coll_d  = coll_q;
                ins_resp_err_d   = 1'b0;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            is_ins_q         <= 1'b0;
            last_ins_q       <= 1'b1;
            prefix_q         <= '0;
            len_q            <= '0;
            coll_q           <= 1'b0;
            mem_rd_en_q      <= 1'b0;
            mem_wr_en_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            lk_resp_valid_q  <= 1'b0;
            lk_resp_hit_q    <= 1'b0;
            lk_resp_len_q    <= '0;
            lk_resp_err_q    <= 1'b0;
            ins_resp_valid_q <= 1'b0;
            ins_resp_coll_q  <= 1'b0;
            ins_resp_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            is_ins_q         <= is_ins_d;
            last_ins_q       <= last_ins_d;
            prefix_q         <= prefix_d;
            len_q            <= len_d;
            coll_q           <= coll_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_wr_en_q      <= mem_wr_en_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            lk_resp_valid_q  <= lk_resp_valid_d;
            lk_resp_hit_q    <= lk_resp_hit_d;
            lk_resp_len_q    <= lk_resp_len_d;
            lk_resp_err_q    <= lk_resp_err_d;
            ins_resp_valid_q <= ins_resp_valid_d;
            ins_resp_coll_q  <= ins_resp_coll_d;
            ins_resp_err_q   <= ins_resp_err_d;
        end
    end

    assign mem_rd_en      = mem_rd_en_q;
    assign mem_wr_en      = mem_wr_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign lk_resp_valid  = lk_resp_valid_q;
    assign lk_resp_hit    = lk_resp_hit_q;
    assign lk_resp_len    = lk_resp_len_q;
    assign lk_resp_err    = lk_resp_err_q;
    assign ins_resp_valid = ins_resp_valid_q;
    assign ins_resp_coll  = ins_resp_coll_q;
    assign ins_resp_err   = ins_resp_err_q;

endmodule
